// File: rtl/acq_sequencer.sv
// ---------------------------------------------------------------------------
// acq_sequencer
//
// Run-level controller between the trigger handler and the ESP32 host
// interface. It arms/disarms triggering, freezes the sample ring buffer
// POST_SAMPLES cycles after a trigger, and signals the host with DATA_READY.
// It runs the READ_REQ/READ_DONE readout handshake and then releases the
// trigger handler through SELF_TRIGGER_RESET. It also keeps event-count,
// trigger-timestamp and dead-time bookkeeping.
//
// Optional build macro: READOUT_TIMEOUT_EN
//   defined   : FROZEN/READOUT are abandoned after READ_TIMEOUT cycles and
//               TIMEOUT_FLAG is set (sticky until the next arm).
//   undefined : FROZEN/READOUT wait indefinitely, TIMEOUT_FLAG is tied to 0.
//
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   RUN_ENABLE          host arm level (1 = run)
//   TRIGGER_IN          trigger handler TRIGGER_OUT level
//   LIVE_ACQUISITION    trigger handler idle indication
//   READ_REQ            host readout request level
//   READ_DONE           host readout finished, single-cycle pulse
//   SOFT_RESET          inhibit to trigger handler (high unless ARMED..READOUT)
//   SELF_TRIGGER_RESET  release to trigger handler (high in RELEASE)
//   BUFFER_FREEZE       stops ring-buffer writes (FROZEN, READOUT)
//   DATA_READY          host interrupt (FROZEN)
//   EVENT_COUNT         accepted events since arm, saturating
//   EVENT_TS            timestamp latched in the trigger cycle
//   DEAD_TIME           cycles spent outside ARMED since arm, saturating
//   STATE               current state encoding (debug / host visibility)
//   TIMEOUT_FLAG        sticky readout-timeout indicator
//
// Readout handshake: DATA_READY rises on entry to FROZEN. The host answers
// with READ_REQ (a level). It is sampled only in FROZEN and moves to READOUT,
// where DATA_READY drops and the buffer stays frozen. The host then ends the
// readout with a single-cycle READ_DONE, which is sampled only in READOUT;
// a READ_DONE seen in any other state is ignored.
//
// All outputs are registered from the next-state value, so they change on
// the same edge as STATE.
// ---------------------------------------------------------------------------
module acq_sequencer #(
    parameter int POST_SAMPLES = 64,
    parameter int TS_WIDTH     = 32,
    parameter int READ_TIMEOUT = 1000000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                RUN_ENABLE,
    input  logic                TRIGGER_IN,
    input  logic                LIVE_ACQUISITION,
    input  logic                READ_REQ,
    input  logic                READ_DONE,
    output logic                SOFT_RESET,
    output logic                SELF_TRIGGER_RESET,
    output logic                BUFFER_FREEZE,
    output logic                DATA_READY,
    output logic [15:0]         EVENT_COUNT,
    output logic [TS_WIDTH-1:0] EVENT_TS,
    output logic [TS_WIDTH-1:0] DEAD_TIME,
    output logic [2:0]          STATE,
    output logic                TIMEOUT_FLAG
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_POST    = 3'd2;
    localparam logic [2:0] S_FROZEN  = 3'd3;
    localparam logic [2:0] S_READOUT = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]          state_q;
    logic [2:0]          state_base;
    logic [2:0]          state_d;
    logic [15:0]         post_cnt_q;
    logic [TS_WIDTH-1:0] ts_q;
    logic                arm_start;
    logic                freeze_entry;
    logic                is_dead;

    assign STATE = state_q;

    // Normal transition rules. A falling RUN_ENABLE is only acted on in
    // ARMED and in RELEASE, so an event in flight is always finished.
    always_comb begin
        state_base = state_q;
        case (state_q)
            S_IDLE:    if (RUN_ENABLE) state_base = S_ARMED;
            S_ARMED: begin
                // Trigger wins over a simultaneous stop request.
                if (TRIGGER_IN)       state_base = S_POST;
                else if (!RUN_ENABLE) state_base = S_IDLE;
            end
            S_POST:    if (post_cnt_q == 16'd1) state_base = S_FROZEN;
            S_FROZEN:  if (READ_REQ)            state_base = S_READOUT;
            S_READOUT: if (READ_DONE)           state_base = S_RELEASE;
            S_RELEASE: begin
                if (LIVE_ACQUISITION && !TRIGGER_IN)
                    state_base = RUN_ENABLE ? S_ARMED : S_IDLE;
            end
            default:   state_base = S_IDLE;
        endcase
    end

`ifdef READOUT_TIMEOUT_EN
    localparam int TMO_W = (READ_TIMEOUT > 1) ? $clog2(READ_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(READ_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             timeout_hit;

    // A normal READ_DONE in the expiring cycle takes precedence, so the
    // event then counts as a clean readout.
    assign timeout_hit = ((state_q == S_FROZEN) || (state_q == S_READOUT)) &&
                         (tmo_q == TMO_LAST) && (state_base != S_RELEASE);
    assign state_d     = timeout_hit ? S_RELEASE : state_base;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tmo_q        <= '0;
            TIMEOUT_FLAG <= 1'b0;
        end else begin
            if (freeze_entry)
                tmo_q <= '0;
            else if ((state_q == S_FROZEN) || (state_q == S_READOUT))
                tmo_q <= tmo_q + TMO_W'(1);

            if (arm_start)
                TIMEOUT_FLAG <= 1'b0;
            else if (timeout_hit)
                TIMEOUT_FLAG <= 1'b1;
        end
    end
`else
    assign state_d      = state_base;
    assign TIMEOUT_FLAG = 1'b0;
`endif

    assign arm_start    = (state_q == S_IDLE) && (state_d == S_ARMED);
    assign freeze_entry = (state_q == S_POST) && (state_d == S_FROZEN);
    assign is_dead      = (state_q == S_POST)    || (state_q == S_FROZEN) ||
                          (state_q == S_READOUT) || (state_q == S_RELEASE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q            <= S_IDLE;
            ts_q               <= '0;
            post_cnt_q         <= '0;
            SOFT_RESET         <= 1'b1;
            SELF_TRIGGER_RESET <= 1'b0;
            BUFFER_FREEZE      <= 1'b0;
            DATA_READY         <= 1'b0;
            EVENT_COUNT        <= '0;
            EVENT_TS           <= '0;
            DEAD_TIME          <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + TS_WIDTH'(1);

            SOFT_RESET         <= !((state_d == S_ARMED)  || (state_d == S_POST) ||
                                    (state_d == S_FROZEN) || (state_d == S_READOUT));
            SELF_TRIGGER_RESET <= (state_d == S_RELEASE);
            BUFFER_FREEZE      <= (state_d == S_FROZEN) || (state_d == S_READOUT);
            DATA_READY         <= (state_d == S_FROZEN);

            // Loading POST_SAMPLES and leaving at count 1 places the freeze
            // exactly POST_SAMPLES edges after the trigger edge.
            if ((state_q == S_ARMED) && (state_d == S_POST)) begin
                EVENT_TS   <= ts_q;
                post_cnt_q <= 16'(POST_SAMPLES);
            end else if (state_q == S_POST) begin
                post_cnt_q <= post_cnt_q - 16'd1;
            end

            if (arm_start) begin
                EVENT_COUNT <= '0;
                DEAD_TIME   <= '0;
            end else begin
                if (freeze_entry && (EVENT_COUNT != 16'hFFFF))
                    EVENT_COUNT <= EVENT_COUNT + 16'd1;
                if (is_dead && (DEAD_TIME != '1))
                    DEAD_TIME <= DEAD_TIME + TS_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_acq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_acq_sequencer
//
// Scenario bench for acq_sequencer. Expected values come from an event-level
// model: the trigger timestamp is the bench's own cycle count since reset,
// event count is the number of completed freezes, and dead time is summed
// from the phase durations the bench itself schedules.
// ---------------------------------------------------------------------------
module tb_acq_sequencer;

    localparam int POST = 64;
    localparam int TS_W = 32;
    localparam int TO   = 100;

    logic            CLK;
    logic            RST_N;
    logic            RUN_ENABLE;
    logic            TRIGGER_IN;
    logic            LIVE_ACQUISITION;
    logic            READ_REQ;
    logic            READ_DONE;
    logic            SOFT_RESET;
    logic            SELF_TRIGGER_RESET;
    logic            BUFFER_FREEZE;
    logic            DATA_READY;
    logic [15:0]     EVENT_COUNT;
    logic [TS_W-1:0] EVENT_TS;
    logic [TS_W-1:0] DEAD_TIME;
    logic [2:0]      STATE;
    logic            TIMEOUT_FLAG;

    acq_sequencer #(
        .POST_SAMPLES(POST),
        .TS_WIDTH    (TS_W),
        .READ_TIMEOUT(TO)
    ) dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .RUN_ENABLE        (RUN_ENABLE),
        .TRIGGER_IN        (TRIGGER_IN),
        .LIVE_ACQUISITION  (LIVE_ACQUISITION),
        .READ_REQ          (READ_REQ),
        .READ_DONE         (READ_DONE),
        .SOFT_RESET        (SOFT_RESET),
        .SELF_TRIGGER_RESET(SELF_TRIGGER_RESET),
        .BUFFER_FREEZE     (BUFFER_FREEZE),
        .DATA_READY        (DATA_READY),
        .EVENT_COUNT       (EVENT_COUNT),
        .EVENT_TS          (EVENT_TS),
        .DEAD_TIME         (DEAD_TIME),
        .STATE             (STATE),
        .TIMEOUT_FLAG      (TIMEOUT_FLAG)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Bench-side cycle count since reset release: the timestamp the DUT
    // must latch.
    logic [TS_W-1:0] tb_ts;
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) tb_ts <= '0;
        else        tb_ts <= tb_ts + 1;
    end

    // ---------------- scoreboard ----------------
    logic [TS_W-1:0] exp_q[$];
    int n_checks;
    int n_errors;
    int exp_events;
    int exp_dead;

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Waits arm_wait cycles in ARMED, raises the trigger, and ticks until the
    // buffer freezes (bounded). Returns state and EVENT_TS after the trigger
    // edge and the number of edges from trigger drive to freeze.
    task automatic fire_trigger(input int arm_wait, output int n_frz,
                                output logic [2:0] st1, output logic [TS_W-1:0] ts1);
        repeat (arm_wait) tick();
        exp_q.push_back(tb_ts);
        TRIGGER_IN       = 1'b1;
        LIVE_ACQUISITION = 1'b0;
        tick();
        st1   = STATE;
        ts1   = EVENT_TS;
        n_frz = 1;
        while (!BUFFER_FREEZE && n_frz < POST + 20) begin
            tick();
            n_frz++;
        end
    endtask

    // Called right after RELEASE was entered: the handler goes idle r3
    // cycles later. Returns how many observed cycles had SELF_TRIGGER_RESET.
    task automatic finish_release(input int r3, output int n_str);
        n_str = SELF_TRIGGER_RESET ? 1 : 0;
        repeat (r3 - 1) begin
            tick();
            if (SELF_TRIGGER_RESET) n_str++;
        end
        TRIGGER_IN       = 1'b0;
        LIVE_ACQUISITION = 1'b1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST_N = 1'b0; RUN_ENABLE = 1'b1; TRIGGER_IN = 1'b0; LIVE_ACQUISITION = 1'b1;
        READ_REQ = 1'b0; READ_DONE = 1'b0;
        repeat (3) tick();
        n_checks++; if (STATE !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", STATE); end
        n_checks++; if (SOFT_RESET !== 1'b1) begin n_errors++; $display("FAIL reset_soft_reset: got %0b want 1", SOFT_RESET); end
        n_checks++; if ({SELF_TRIGGER_RESET, BUFFER_FREEZE, DATA_READY, TIMEOUT_FLAG} !== 4'b0)
            begin n_errors++; $display("FAIL reset_flags: got %b want 0000", {SELF_TRIGGER_RESET, BUFFER_FREEZE, DATA_READY, TIMEOUT_FLAG}); end
        n_checks++; if ({EVENT_COUNT, EVENT_TS, DEAD_TIME} !== '0)
            begin n_errors++; $display("FAIL reset_counters: cnt=%0d ts=%0d dead=%0d want 0", EVENT_COUNT, EVENT_TS, DEAD_TIME); end
        RST_N = 1'b1;
        tick();
        exp_events = 0; exp_dead = 0;
        n_checks++; if (STATE !== 3'd1) begin n_errors++; $display("FAIL arm_state: got %0d want 1", STATE); end
        n_checks++; if (SOFT_RESET !== 1'b0) begin n_errors++; $display("FAIL arm_soft_reset: got %0b want 0", SOFT_RESET); end
        n_checks++; if (EVENT_COUNT !== 16'd0) begin n_errors++; $display("FAIL arm_count: got %0d want 0", EVENT_COUNT); end
    endtask

    task automatic test_event(input int arm_wait, input int r1, input int r2, input int r3);
        int n_frz, n_str;
        logic [2:0] st1;
        logic [TS_W-1:0] ts1, exp_ts;
        fire_trigger(arm_wait, n_frz, st1, ts1);
        exp_ts = exp_q.pop_front();
        exp_events++;
        exp_dead += POST;
        n_checks++; if (st1 !== 3'd2) begin n_errors++; $display("FAIL ev_post_state: got %0d want 2", st1); end
        n_checks++; if (ts1 !== exp_ts) begin n_errors++; $display("FAIL ev_timestamp: got %0d want %0d", ts1, exp_ts); end
        n_checks++; if (n_frz !== POST + 1) begin n_errors++; $display("FAIL ev_freeze_delay: got %0d want %0d", n_frz - 1, POST); end
        n_checks++; if ({STATE, DATA_READY} !== {3'd3, 1'b1}) begin n_errors++; $display("FAIL ev_frozen: state=%0d dr=%0b want 3/1", STATE, DATA_READY); end
        n_checks++; if (EVENT_COUNT !== 16'(exp_events)) begin n_errors++; $display("FAIL ev_count: got %0d want %0d", EVENT_COUNT, exp_events); end
        repeat (r1) tick();
        READ_REQ = 1'b1;
        tick();
        exp_dead += r1 + 1;
        n_checks++; if ({STATE, DATA_READY, BUFFER_FREEZE} !== {3'd4, 1'b0, 1'b1})
            begin n_errors++; $display("FAIL ev_readout: state=%0d dr=%0b frz=%0b want 4/0/1", STATE, DATA_READY, BUFFER_FREEZE); end
        repeat (r2) tick();
        READ_DONE = 1'b1;
        tick();
        READ_DONE = 1'b0; READ_REQ = 1'b0;
        exp_dead += r2 + 1;
        n_checks++; if ({STATE, SELF_TRIGGER_RESET, BUFFER_FREEZE} !== {3'd5, 1'b1, 1'b0})
            begin n_errors++; $display("FAIL ev_release: state=%0d str=%0b frz=%0b want 5/1/0", STATE, SELF_TRIGGER_RESET, BUFFER_FREEZE); end
        finish_release(r3, n_str);
        exp_dead += r3;
        n_checks++; if (n_str !== r3) begin n_errors++; $display("FAIL ev_str_width: got %0d want %0d", n_str, r3); end
        n_checks++; if ({STATE, SELF_TRIGGER_RESET, SOFT_RESET} !== {3'd1, 1'b0, 1'b0})
            begin n_errors++; $display("FAIL ev_rearmed: state=%0d str=%0b soft=%0b want 1/0/0", STATE, SELF_TRIGGER_RESET, SOFT_RESET); end
        n_checks++; if (DEAD_TIME !== TS_W'(exp_dead)) begin n_errors++; $display("FAIL ev_dead_time: got %0d want %0d", DEAD_TIME, exp_dead); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++)
            test_event($urandom_range(0, 8), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(1, 6));
    endtask

    task automatic test_stop_in_readout();
        int n_frz, n_str, n_bad;
        logic [2:0] st1;
        logic [TS_W-1:0] ts1, exp_ts;
        fire_trigger($urandom_range(0, 5), n_frz, st1, ts1);
        exp_ts = exp_q.pop_front();
        exp_events++;
        READ_REQ = 1'b1;
        tick();
        RUN_ENABLE = 1'b0;
        tick();
        n_checks++; if ({STATE, BUFFER_FREEZE, SOFT_RESET} !== {3'd4, 1'b1, 1'b0})
            begin n_errors++; $display("FAIL stop_keeps_readout: state=%0d frz=%0b soft=%0b want 4/1/0", STATE, BUFFER_FREEZE, SOFT_RESET); end
        READ_DONE = 1'b1;
        tick();
        READ_DONE = 1'b0; READ_REQ = 1'b0;
        n_checks++; if (STATE !== 3'd5) begin n_errors++; $display("FAIL stop_release: got %0d want 5", STATE); end
        finish_release(2, n_str);
        exp_dead += POST + 1 + 2 + 2;
        n_checks++; if ({STATE, SOFT_RESET} !== {3'd0, 1'b1}) begin n_errors++; $display("FAIL stop_idle: state=%0d soft=%0b want 0/1", STATE, SOFT_RESET); end
        n_checks++; if (DEAD_TIME !== TS_W'(exp_dead)) begin n_errors++; $display("FAIL stop_dead_time: got %0d want %0d", DEAD_TIME, exp_dead); end
        n_checks++; if (ts1 !== exp_ts) begin n_errors++; $display("FAIL stop_timestamp: got %0d want %0d", ts1, exp_ts); end
        TRIGGER_IN = 1'b1; LIVE_ACQUISITION = 1'b0;
        n_bad = 0;
        repeat (8) begin
            tick();
            if (STATE !== 3'd0 || BUFFER_FREEZE !== 1'b0) n_bad++;
        end
        TRIGGER_IN = 1'b0; LIVE_ACQUISITION = 1'b1;
        n_checks++; if (n_bad !== 0) begin n_errors++; $display("FAIL stop_ignores_trigger: %0d bad cycles want 0", n_bad); end
        n_checks++; if (EVENT_COUNT !== 16'(exp_events)) begin n_errors++; $display("FAIL stop_count: got %0d want %0d", EVENT_COUNT, exp_events); end
    endtask

    task automatic test_stray_signals();
        int n_frz, n_str, r2, r3;
        logic [2:0] st1;
        logic [TS_W-1:0] ts1, exp_ts;
        RUN_ENABLE = 1'b1;
        tick();
        exp_events = 0; exp_dead = 0;
        n_checks++; if ({STATE, EVENT_COUNT, DEAD_TIME} !== {3'd1, 16'd0, TS_W'(0)})
            begin n_errors++; $display("FAIL rearm_clear: state=%0d cnt=%0d dead=%0d want 1/0/0", STATE, EVENT_COUNT, DEAD_TIME); end
        READ_DONE = 1'b1;
        tick();
        READ_DONE = 1'b0;
        tick();
        n_checks++; if (STATE !== 3'd1) begin n_errors++; $display("FAIL stray_read_done: got %0d want 1", STATE); end
        READ_REQ = 1'b1;
        fire_trigger($urandom_range(0, 5), n_frz, st1, ts1);
        exp_ts = exp_q.pop_front();
        exp_events++;
        n_checks++; if ({STATE, DATA_READY} !== {3'd3, 1'b1}) begin n_errors++; $display("FAIL early_req_frozen: state=%0d dr=%0b want 3/1", STATE, DATA_READY); end
        tick();
        n_checks++; if ({STATE, DATA_READY} !== {3'd4, 1'b0}) begin n_errors++; $display("FAIL early_req_single_dr: state=%0d dr=%0b want 4/0", STATE, DATA_READY); end
        r2 = $urandom_range(0, 10);
        r3 = $urandom_range(1, 5);
        repeat (r2) tick();
        READ_DONE = 1'b1;
        tick();
        READ_DONE = 1'b0; READ_REQ = 1'b0;
        finish_release(r3, n_str);
        exp_dead += POST + 1 + (r2 + 1) + r3;
        n_checks++; if (DEAD_TIME !== TS_W'(exp_dead)) begin n_errors++; $display("FAIL early_req_dead: got %0d want %0d", DEAD_TIME, exp_dead); end
        n_checks++; if ({STATE, EVENT_COUNT} !== {3'd1, 16'(exp_events)}) begin n_errors++; $display("FAIL early_req_done: state=%0d cnt=%0d want 1/%0d", STATE, EVENT_COUNT, exp_events); end
        n_checks++; if (ts1 !== exp_ts) begin n_errors++; $display("FAIL early_req_ts: got %0d want %0d", ts1, exp_ts); end
    endtask

    task automatic test_trigger_vs_stop();
        int n_frz, n_str;
        logic [2:0] st1;
        logic [TS_W-1:0] ts1, exp_ts;
        RUN_ENABLE = 1'b0;
        fire_trigger(0, n_frz, st1, ts1);
        exp_ts = exp_q.pop_front();
        exp_events++;
        n_checks++; if (st1 !== 3'd2) begin n_errors++; $display("FAIL trig_wins: got %0d want 2", st1); end
        n_checks++; if (ts1 !== exp_ts) begin n_errors++; $display("FAIL trig_wins_ts: got %0d want %0d", ts1, exp_ts); end
        READ_REQ = 1'b1;
        tick();
        READ_DONE = 1'b1;
        tick();
        READ_DONE = 1'b0; READ_REQ = 1'b0;
        finish_release(3, n_str);
        exp_dead += POST + 1 + 1 + 3;
        n_checks++; if ({STATE, SOFT_RESET} !== {3'd0, 1'b1}) begin n_errors++; $display("FAIL trig_wins_idle: state=%0d soft=%0b want 0/1", STATE, SOFT_RESET); end
        n_checks++; if (EVENT_COUNT !== 16'(exp_events)) begin n_errors++; $display("FAIL trig_wins_count: got %0d want %0d", EVENT_COUNT, exp_events); end
        n_checks++; if (DEAD_TIME !== TS_W'(exp_dead)) begin n_errors++; $display("FAIL trig_wins_dead: got %0d want %0d", DEAD_TIME, exp_dead); end
    endtask

    task automatic test_timeout();
        int n_frz, n_str, n, r3;
        logic [2:0] st1;
        logic [TS_W-1:0] ts1, exp_ts;
        RUN_ENABLE = 1'b1;
        tick();
        exp_events = 0; exp_dead = 0;
        fire_trigger($urandom_range(0, 5), n_frz, st1, ts1);
        exp_ts = exp_q.pop_front();
        exp_events++;
        r3 = $urandom_range(1, 4);
`ifdef READOUT_TIMEOUT_EN
        n = 0;
        while (STATE !== 3'd5 && n < 3 * TO) begin
            tick();
            n++;
        end
        n_checks++; if (n !== TO) begin n_errors++; $display("FAIL timeout_delay: got %0d want %0d", n, TO); end
        n_checks++; if ({TIMEOUT_FLAG, BUFFER_FREEZE} !== 2'b10) begin n_errors++; $display("FAIL timeout_flag: flag=%0b frz=%0b want 1/0", TIMEOUT_FLAG, BUFFER_FREEZE); end
        n_checks++; if (EVENT_COUNT !== 16'(exp_events)) begin n_errors++; $display("FAIL timeout_count: got %0d want %0d", EVENT_COUNT, exp_events); end
        finish_release(r3, n_str);
        exp_dead += POST + TO + r3;
        n_checks++; if (TIMEOUT_FLAG !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky: got %0b want 1", TIMEOUT_FLAG); end
`else
        n = 0;
        repeat (10000) begin
            tick();
            if (STATE !== 3'd3 || DATA_READY !== 1'b1) n++;
        end
        n_checks++; if (n !== 0) begin n_errors++; $display("FAIL frozen_hold: %0d cycles left FROZEN want 0", n); end
        n_checks++; if (TIMEOUT_FLAG !== 1'b0) begin n_errors++; $display("FAIL no_timeout_flag: got %0b want 0", TIMEOUT_FLAG); end
        READ_REQ = 1'b1;
        tick();
        READ_DONE = 1'b1;
        tick();
        READ_DONE = 1'b0; READ_REQ = 1'b0;
        finish_release(r3, n_str);
        exp_dead += POST + 10001 + 1 + r3;
`endif
        n_checks++; if (STATE !== 3'd1) begin n_errors++; $display("FAIL timeout_rearm: got %0d want 1", STATE); end
        n_checks++; if (DEAD_TIME !== TS_W'(exp_dead)) begin n_errors++; $display("FAIL timeout_dead: got %0d want %0d", DEAD_TIME, exp_dead); end
        n_checks++; if (ts1 !== exp_ts) begin n_errors++; $display("FAIL timeout_ts: got %0d want %0d", ts1, exp_ts); end
    endtask

    task automatic test_reset_mid();
        int n_frz;
        logic [2:0] st1;
        logic [TS_W-1:0] ts1, exp_ts;
        fire_trigger($urandom_range(0, 5), n_frz, st1, ts1);
        exp_ts = exp_q.pop_front();
        n_checks++; if (BUFFER_FREEZE !== 1'b1) begin n_errors++; $display("FAIL pre_reset_frozen: got %0b want 1", BUFFER_FREEZE); end
        #2 RST_N = 1'b0;
        #1;
        n_checks++; if ({STATE, SOFT_RESET, BUFFER_FREEZE, DATA_READY} !== {3'd0, 1'b1, 1'b0, 1'b0})
            begin n_errors++; $display("FAIL async_reset: state=%0d soft=%0b frz=%0b dr=%0b want 0/1/0/0", STATE, SOFT_RESET, BUFFER_FREEZE, DATA_READY); end
        n_checks++; if ({EVENT_COUNT, EVENT_TS, DEAD_TIME} !== '0)
            begin n_errors++; $display("FAIL async_reset_cnt: cnt=%0d ts=%0d dead=%0d want 0", EVENT_COUNT, EVENT_TS, DEAD_TIME); end
        TRIGGER_IN = 1'b0; LIVE_ACQUISITION = 1'b1; RUN_ENABLE = 1'b1;
        #2 RST_N = 1'b1;
        tick();
        exp_events = 0; exp_dead = 0;
        n_checks++; if (STATE !== 3'd1) begin n_errors++; $display("FAIL post_reset_arm: got %0d want 1", STATE); end
        n_checks++; if (ts1 !== exp_ts) begin n_errors++; $display("FAIL pre_reset_ts: got %0d want %0d", ts1, exp_ts); end
        // The event after reset checks that the timestamp restarted from 0.
        test_event($urandom_range(3, 30), $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(1, 4));
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_event(500 - int'(tb_ts), 10, 20, 3);
        test_back_to_back();
        test_stop_in_readout();
        test_stray_signals();
        test_trigger_vs_stop();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Run-level controller sitting between the trigger handler and the ESP32 host interface. Arms and disarms triggering, and freezes the sample ring buffer after a trigger plus a post-trigger window. Raises DATA_READY to the host and runs the READ_REQ/READ_DONE handshake. Then releases the trigger handler by driving SELF_TRIGGER_RESET, and keeps event, timestamp and dead-time bookkeeping.

Parameters:
POST_SAMPLES, 64, cycles between trigger assertion and buffer freeze (1..65535)
TS_WIDTH, 32, width of free-running timestamp and dead-time counters
READ_TIMEOUT, 1000000, cycles allowed in FROZEN/READOUT before forced release (used only with READOUT_TIMEOUT_EN)

Ports:
CLK  in  1  system clock
RST_N  in  1  reset, asynchronous, active-low
RUN_ENABLE  in  1  host arm level; 1=run, 0=stop
TRIGGER_IN  in  1  trigger handler TRIGGER_OUT (level, held until released)
LIVE_ACQUISITION  in  1  trigger handler idle indication
READ_REQ  in  1  host starts readout (level)
READ_DONE  in  1  host finished readout (single-cycle pulse)
SOFT_RESET  out  1  inhibits trigger handler; high whenever not ARMED/POST/FROZEN/READOUT
SELF_TRIGGER_RESET  out  1  release to trigger handler
BUFFER_FREEZE  out  1  stops ring-buffer writes
DATA_READY  out  1  host interrupt
EVENT_COUNT  out  16  accepted events since arm, saturating
EVENT_TS  out  TS_WIDTH  timestamp latched at trigger
DEAD_TIME  out  TS_WIDTH  cumulative cycles not in ARMED since arm, saturating
STATE  out  3  current state encoding
TIMEOUT_FLAG  out  1  sticky readout-timeout indicator

Behaviour:
- Reset values: state IDLE; SOFT_RESET=1; all other outputs 0; timestamp counter 0.
- Timestamp counter: free-running, increments every cycle, wraps modulo 2^TS_WIDTH, cleared only by RST_N.
- All outputs are registered; state-derived outputs change 1 cycle after the transition condition is sampled.
- States (encoding): IDLE=0, ARMED=1, POST=2, FROZEN=3, READOUT=4, RELEASE=5.
- IDLE:
  - On RUN_ENABLE=1, go to ARMED.
  - On that transition, clear EVENT_COUNT, DEAD_TIME and TIMEOUT_FLAG.
- ARMED:
  - SOFT_RESET=0.
  - On TRIGGER_IN=1, latch EVENT_TS = timestamp in that cycle, load post counter with POST_SAMPLES, go to POST.
- POST:
  - Decrement the post counter each cycle.
  - When counter==1, go to FROZEN; BUFFER_FREEZE goes high exactly POST_SAMPLES cycles after TRIGGER_IN was sampled.
  - EVENT_COUNT increments (saturating at 0xFFFF) on entry to FROZEN.
- FROZEN:
  - BUFFER_FREEZE=1, DATA_READY=1.
  - On READ_REQ=1, go to READOUT.
- READOUT:
  - BUFFER_FREEZE=1, DATA_READY=0.
  - On READ_DONE, go to RELEASE.
  - READ_DONE received outside READOUT is ignored.
- RELEASE:
  - SELF_TRIGGER_RESET=1, BUFFER_FREEZE=0.
  - Hold until LIVE_ACQUISITION=1 and TRIGGER_IN=0.
  - Then drop SELF_TRIGGER_RESET and go to ARMED if RUN_ENABLE=1, else IDLE.
- DEAD_TIME: increments every cycle the state is POST, FROZEN, READOUT or RELEASE; saturates at all-ones.
- RUN_ENABLE falling:
  - In ARMED: go to IDLE next cycle.
  - In POST/FROZEN/READOUT: finish the current event through RELEASE, then IDLE. No event is abandoned mid-readout.
- Simultaneous events:
  - TRIGGER_IN and RUN_ENABLE falling in ARMED: the trigger wins, the event is processed, then IDLE.
  - READ_REQ already high on FROZEN entry: go to READOUT the next cycle; DATA_READY is high for exactly 1 cycle.
- RST_N asserted mid-operation: immediately return to reset values, including releasing BUFFER_FREEZE. The trigger handler is held off via SOFT_RESET=1.

Optional Feature:
READOUT_TIMEOUT_EN:
- When defined:
  - A counter runs while in FROZEN or READOUT; it is cleared on entry to FROZEN.
  - When it reaches READ_TIMEOUT, go to RELEASE, set TIMEOUT_FLAG=1 (sticky until the next arm), and EVENT_COUNT still counts the event.
- When undefined:
  - No counter is present; FROZEN/READOUT wait indefinitely.
  - TIMEOUT_FLAG is tied to 0.

Test Plan:
1. Reset with RUN_ENABLE=1, then release -> STATE=1 after 1 cycle, SOFT_RESET=0, EVENT_COUNT=0.
2. POST_SAMPLES=64; TRIGGER_IN at timestamp 500 -> EVENT_TS=500, BUFFER_FREEZE and DATA_READY rise 64 cycles later, EVENT_COUNT=1.
3. FROZEN, READ_REQ after 10 cycles, READ_DONE after 20 more; LIVE_ACQUISITION returns 3 cycles after SELF_TRIGGER_RESET -> SELF_TRIGGER_RESET high exactly 3 cycles then back to ARMED, DEAD_TIME=64+10+20+3 (±1 per defined entry cycle).
4. RUN_ENABLE dropped during READOUT -> readout completes, RELEASE then STATE=0, SOFT_RESET=1; later triggers ignored.
5. READ_DONE pulsed while ARMED; READ_REQ held high before freeze -> no state change from READ_DONE; DATA_READY high for a single cycle.
6. With READOUT_TIMEOUT_EN, READ_TIMEOUT=100, no READ_REQ -> RELEASE at cycle 100 after freeze, TIMEOUT_FLAG=1, EVENT_COUNT incremented; without macro, FROZEN holds for 10000 cycles.
